// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data_mem_sync block.
// Optional feature macro used by this block: DMEM_PARITY_EN.
package dmem_pkg;

  localparam int DMEM_DATA_W = 19;
  localparam int DMEM_ADDR_W = 14;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Even parity over a word zero-extended to 64 bits.
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/data_mem_sync_if.sv
// Request/response channel of data_mem_sync.
// DMEM_PARITY_EN adds par_flip and rsp_par_err.
interface data_mem_sync_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_busy;
`ifdef DMEM_PARITY_EN
  logic              par_flip;
  logic              rsp_par_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, par_flip,
    input  req_ready, rsp_valid, rsp_rdata, init_busy, rsp_par_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, par_flip,
    output req_ready, rsp_valid, rsp_rdata, init_busy, rsp_par_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, init_busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, init_busy
  );
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port storage: synchronous write, registered read. The read register
// only changes on a read or a clear, so it doubles as the response holding slot.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WORD_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rd_clr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr)       rdata_d = '0;
    else if (rd_en)   rdata_d = rd_zero ? '0 : mem_q[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (wr_en) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_sync.sv
// Synchronous data memory with valid/ready requests, registered read response
// and a hardware zero-clear after every reset. Optional: DMEM_PARITY_EN.
//
// state | meaning
// CLEAR | writing zero to word[cnt], requests blocked, init_busy=1
// RUN   | servicing requests until the next reset
module data_mem_sync
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_sync_if.slave   bus
);
`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              clearing;
  logic              in_range;
  logic              req_ready;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] arr_rdata;

  assign clearing  = (state_q == CLEAR);
  assign in_range  = 32'(bus.req_addr) < 32'(DEPTH);
  // Slot is free when empty or being drained this very cycle.
  assign req_ready = !clearing && !(rsp_valid_q && !bus.rsp_ready);
  assign rd_acc    = bus.req_valid && req_ready && !bus.req_we;
  assign wr_acc    = bus.req_valid && req_ready && bus.req_we && in_range;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    if (clearing) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
    end
    if (rd_acc)              rsp_valid_d = 1'b1;
    else if (bus.rsp_ready)  rsp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef DMEM_PARITY_EN
  assign new_word = {parity(64'(bus.req_wdata)) ^ bus.par_flip, bus.req_wdata};
  assign bus.rsp_par_err = rsp_valid_q &&
                           (parity(64'(arr_rdata[DATA_W-1:0])) != arr_rdata[DATA_W]);
`else
  assign new_word = bus.req_wdata;
`endif

  assign arr_addr  = clearing ? cnt_q : bus.req_addr;
  assign arr_wdata = clearing ? '0 : new_word;

  dmem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rd_clr  (reset),
    .wr_en   (!reset && (clearing || wr_acc)),
    .rd_en   (!reset && rd_acc),
    .rd_zero (!in_range),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = arr_rdata[DATA_W-1:0];
  assign bus.init_busy = clearing;
endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync (DEPTH=1000): vector table plus clear,
// backpressure and reset sequences. Parity checks run under DMEM_PARITY_EN.
module tb_data_mem_sync;
  localparam int DATA_W = 19;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  data_mem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    check({tag, "_busy"},  32'(bus.init_busy), 32'd1);
`ifdef DMEM_PARITY_EN
    check({tag, "_parerr"}, 32'(bus.rsp_par_err), 32'd0);
`endif
  endtask

  // Called in the first cycle with reset=0; counts busy cycles.
  task automatic run_clear(input string tag);
    int n = 0;
    bit early_ready = 0;
    while (bus.init_busy && n < DEPTH + 10) begin
      if (bus.req_ready) early_ready = 1;
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(DEPTH));
    check({tag, "_ready_during_clear"}, 32'(early_ready), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    tick();
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic flip);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef DMEM_PARITY_EN
    bus.par_flip  = flip;
`else
    if (flip) $display("note: par_flip ignored in this build");
`endif
    tick();
    bus.req_valid = 1'b0;
`ifdef DMEM_PARITY_EN
    bus.par_flip  = 1'b0;
`endif
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                         input string tag);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rsp_rdata), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 14'd5,      19'h7FFFF, 19'h00000};
    vecs[1]  = '{1'b0, 14'd5,      19'h00000, 19'h7FFFF};
    vecs[2]  = '{1'b0, 14'd6,      19'h00000, 19'h00000};
    vecs[3]  = '{1'b1, 14'd999,    19'h2AAAA, 19'h00000};
    vecs[4]  = '{1'b1, 14'd1000,   19'h12345, 19'h00000};
    vecs[5]  = '{1'b0, 14'd1000,   19'h00000, 19'h00000};
    vecs[6]  = '{1'b0, 14'd999,    19'h00000, 19'h2AAAA};
    vecs[7]  = '{1'b1, 14'd0,      19'h00001, 19'h00000};
    vecs[8]  = '{1'b0, 14'd0,      19'h00000, 19'h00001};
    vecs[9]  = '{1'b0, 14'h3FFF,   19'h00000, 19'h00000};
    vecs[10] = '{1'b0, 14'd1,      19'h00000, 19'h00000};
    vecs[11] = '{1'b1, 14'd5,      19'h15555, 19'h00000};
    vecs[12] = '{1'b0, 14'd5,      19'h00000, 19'h15555};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
`ifdef DMEM_PARITY_EN
    bus.par_flip  = 1'b0;
`endif
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    run_clear("por_clear");

    // Back-to-back vectors at full rate.
    for (int i = 0; i < 13; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = vecs[i].we;
      bus.req_addr  = vecs[i].addr;
      bus.req_wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'd1);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'(!vecs[i].we));
      if (!vecs[i].we)
        check($sformatf("vec%0d_data", i), 32'(bus.rsp_rdata), 32'(vecs[i].exp));
    end
    bus.req_valid = 1'b0;
    tick();
    check("drain_valid", 32'(bus.rsp_valid), 32'd0);
    check("drain_hold",  32'(bus.rsp_rdata), 32'h15555);

    // Reset with nonzero contents and a nonzero held response.
    pulse_reset("rst2");
    run_clear("rst2_clear");
    do_read(14'd0,    19'h0, "clr_rd0");
    do_read(14'd999,  19'h0, "clr_rd999");
    do_read(14'd5,    19'h0, "clr_rd5");
    do_read(14'h3FFF, 19'h0, "clr_rd3fff");

    // Backpressure: two reads, consumer stalls three cycles.
    do_write(14'd1, 19'h11111, 1'b0);
    do_write(14'd2, 19'h22222, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'd1;
    tick();
    bus.req_addr  = 14'd2;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", c),  32'(bus.rsp_rdata), 32'h11111);
      check($sformatf("bp%0d_ready", c), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("bp_second_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_second_data",  32'(bus.rsp_rdata), 32'h22222);
    tick();
    check("bp_end_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset while a response is pending.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 14'd1;
    tick();
    bus.req_valid = 1'b0;
    check("pend_valid", 32'(bus.rsp_valid), 32'd1);
    pulse_reset("pend_rst");
    bus.rsp_ready = 1'b1;
    run_clear("pend_clear");

    // Reset in the middle of a clear.
    pulse_reset("mid_rst");
    for (int c = 0; c < 500; c++) tick();
    check("mid_busy_500", 32'(bus.init_busy), 32'd1);
    pulse_reset("mid_rst2");
    run_clear("mid_clear");

`ifdef DMEM_PARITY_EN
    do_write(14'd7, 19'h00001, 1'b1);
    do_read(14'd7, 19'h00001, "par_flip_rd");
    check("par_flip_err", 32'(bus.rsp_par_err), 32'd1);
    do_write(14'd7, 19'h00001, 1'b0);
    do_read(14'd7, 19'h00001, "par_ok_rd");
    check("par_ok_err", 32'(bus.rsp_par_err), 32'd0);
    do_read(14'd8, 19'h0, "par_clr_rd");
    check("par_clr_err", 32'(bus.rsp_par_err), 32'd0);
    do_read(14'd1000, 19'h0, "par_oor_rd");
    check("par_oor_err", 32'(bus.rsp_par_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
